// File: rtl/boa_arb_pkg.sv
// Shared types and the tie-break helper for the two-master memory arbiter.
// The optional round-robin mode is selected with the macro BOA_MEM_ARBITER_RR_EN.
package boa_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } arb_sel_t;

    // A single request always wins. On a tie, the master that was not served last wins.
    // Fixed priority passes last=SEL_B so that A wins, unless force_b reports B as starved.
    function automatic arb_sel_t arb_pick(input logic     req_a,
                                          input logic     req_b,
                                          input arb_sel_t last,
                                          input logic     force_b);
        arb_sel_t pick;
        pick = SEL_NONE;
        if (req_a && req_b) begin
            if (force_b || (last == SEL_A)) pick = SEL_B;
            else                            pick = SEL_A;
        end else if (req_a) begin
            pick = SEL_A;
        end else if (req_b) begin
            pick = SEL_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Simple request/ready memory bus. CPU drives the request and MEM drives the response.
// Handshake: a request (re=1 or we!=0) is accepted on the cycle ready=1. It must be
// held stable until then. Read data arrives on rdata the cycle after the accept.
interface boa_mem_bus;
    import boa_arb_pkg::*;

    logic              re;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport CPU (output re, we, addr, wdata, input ready, rdata);
    modport MEM (input re, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/boa_mem_arbiter.sv
// Two-master arbiter that merges masters A and B onto one single-port memory.
// A grant is held across memory stalls. Registered read data is routed back to the
// master that owns the response.
// Macro BOA_MEM_ARBITER_RR_EN: defined selects round-robin ties, undefined selects
// fixed priority (A wins ties) with a starvation override for B.
module boa_mem_arbiter
    import boa_arb_pkg::*;
#(
    parameter int starve_limit = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    boa_mem_bus.MEM        a,
    boa_mem_bus.MEM        b,
    boa_mem_bus.CPU        mem,
    output arb_sel_t       dbg_gnt,
    output arb_sel_t       dbg_rsp,
    output logic [7:0]     dbg_starve
);

    localparam logic [7:0] STARVE_LIM = 8'(starve_limit);

    arb_sel_t   gnt_q;
    arb_sel_t   rsp_q;
    arb_sel_t   rr_last_q;
    arb_sel_t   sel;
    logic [7:0] starve_q;
    logic       req_a;
    logic       req_b;
    logic       force_b;
    logic       accept;

    assign dbg_gnt    = gnt_q;
    assign dbg_rsp    = rsp_q;
    assign dbg_starve = starve_q;

    // Pick the owner of this cycle and mux its request down and the ready/rdata back up.
    always_comb begin
        req_a   = a.re | (|a.we);
        req_b   = b.re | (|b.we);
        force_b = (starve_q >= STARVE_LIM);
        sel     = SEL_NONE;
        // While reset is asserted, nothing reaches the memory, including during an aborted lock.
        if (!rst_n)                  sel = SEL_NONE;
        else if (gnt_q != SEL_NONE)  sel = gnt_q;
        else                         sel = arb_pick(req_a, req_b, rr_last_q, force_b);
        accept    = (sel != SEL_NONE) && mem.ready;

        mem.re    = 1'b0;
        mem.we    = '0;
        mem.addr  = '0;
        mem.wdata = '0;
        case (sel)
            SEL_A: begin
                mem.re    = a.re;
                mem.we    = a.we;
                mem.addr  = a.addr;
                mem.wdata = a.wdata;
            end
            SEL_B: begin
                mem.re    = b.re;
                mem.we    = b.we;
                mem.addr  = b.addr;
                mem.wdata = b.wdata;
            end
            default: ;
        endcase

        a.ready = (sel == SEL_A) && mem.ready;
        b.ready = (sel == SEL_B) && mem.ready;
        a.rdata = (rsp_q == SEL_A) ? mem.rdata : '0;
        b.rdata = (rsp_q == SEL_B) ? mem.rdata : '0;
    end

    // Grant lock, response owner, round-robin history and B starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= SEL_NONE;
            rsp_q     <= SEL_NONE;
            rr_last_q <= SEL_B;
            starve_q  <= '0;
        end else begin
            gnt_q <= ((sel != SEL_NONE) && !mem.ready) ? sel : SEL_NONE;
            rsp_q <= accept ? sel : SEL_NONE;
`ifdef BOA_MEM_ARBITER_RR_EN
            if (accept) rr_last_q <= sel;
            starve_q <= '0;
`else
            // rr_last_q is held at SEL_B so that arb_pick resolves ties to A.
            rr_last_q <= SEL_B;
            if (accept && (sel == SEL_B))         starve_q <= '0;
            else if (req_b && (starve_q != 8'hFF)) starve_q <= starve_q + 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Bench for boa_mem_arbiter driving a 256-word block RAM with a one-cycle read latency.
module tb_boa_mem_arbiter;
    import boa_arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       mem_ready;
    arb_sel_t   dbg_gnt;
    arb_sel_t   dbg_rsp;
    logic [7:0] dbg_starve;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    arb_sel_t    own_q[$];
    logic        rd_q[$];
    logic [31:0] model [0:255] = '{default: 32'h0};
    logic [31:0] ram   [0:255] = '{default: 32'h0};

    arb_sel_t fix_seq [8] = '{SEL_A, SEL_A, SEL_A, SEL_B, SEL_A, SEL_A, SEL_A, SEL_B};
    int       fix_stv [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    arb_sel_t rr_seq  [6] = '{SEL_A, SEL_B, SEL_A, SEL_B, SEL_A, SEL_B};

    boa_mem_bus a_bus ();
    boa_mem_bus b_bus ();
    boa_mem_bus m_bus ();

    boa_mem_arbiter #(.starve_limit(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a_bus),
        .b          (b_bus),
        .mem        (m_bus),
        .dbg_gnt    (dbg_gnt),
        .dbg_rsp    (dbg_rsp),
        .dbg_starve (dbg_starve)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM with byte enables and a registered read port.
    assign m_bus.ready = mem_ready;
    always @(posedge clk) begin
        if (m_bus.ready) begin
            if (m_bus.re) m_bus.rdata <= ram[m_bus.addr[9:2]];
            for (int i = 0; i < 4; i++)
                if (m_bus.we[i]) ram[m_bus.addr[9:2]][8*i +: 8] <= m_bus.wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks.
    task automatic idle_all();
        a_bus.re = 1'b0; a_bus.we = 4'h0; a_bus.addr = '0; a_bus.wdata = '0;
        b_bus.re = 1'b0; b_bus.we = 4'h0; b_bus.addr = '0; b_bus.wdata = '0;
    endtask

    task automatic drive_a(input logic re, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        a_bus.re = re; a_bus.we = we; a_bus.addr = addr; a_bus.wdata = wdata;
    endtask

    task automatic drive_b(input logic re, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        b_bus.re = re; b_bus.we = we; b_bus.addr = addr; b_bus.wdata = wdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: check the response to last cycle's accept, check this cycle's grant,
    // record any new accept in the scoreboard, then advance to the next falling edge.
    task automatic step(input arb_sel_t exp_sel);
        arb_sel_t    own;
        logic        rd;
        logic [31:0] d;
        logic        w_re;
        logic [3:0]  w_we;
        logic [31:0] w_addr;
        logic [31:0] w_data;
        #1;
        own = SEL_NONE; rd = 1'b0; d = '0;
        if (own_q.size() > 0) begin
            own = own_q.pop_front();
            rd  = rd_q.pop_front();
            d   = exp_q.pop_front();
        end
        chk("rsp_owner", 32'(dbg_rsp), 32'(own));
        if (own != SEL_A)  chk("a_rdata_idle", a_bus.rdata, 32'h0);
        else if (rd)       chk("a_rdata", a_bus.rdata, d);
        if (own != SEL_B)  chk("b_rdata_idle", b_bus.rdata, 32'h0);
        else if (rd)       chk("b_rdata", b_bus.rdata, d);

        w_re = 1'b0; w_we = 4'h0; w_addr = '0; w_data = '0;
        if (exp_sel == SEL_A) begin
            w_re = a_bus.re; w_we = a_bus.we; w_addr = a_bus.addr; w_data = a_bus.wdata;
        end else if (exp_sel == SEL_B) begin
            w_re = b_bus.re; w_we = b_bus.we; w_addr = b_bus.addr; w_data = b_bus.wdata;
        end
        chk("a_ready", 32'(a_bus.ready), 32'((exp_sel == SEL_A) && mem_ready));
        chk("b_ready", 32'(b_bus.ready), 32'((exp_sel == SEL_B) && mem_ready));
        chk("mem_addr", m_bus.addr, w_addr);
        chk("mem_re", 32'(m_bus.re), 32'(w_re));
        chk("mem_we", 32'(m_bus.we), 32'(w_we));

        if ((exp_sel != SEL_NONE) && mem_ready) begin
            for (int i = 0; i < 4; i++)
                if (w_we[i]) model[w_addr[9:2]][8*i +: 8] = w_data[8*i +: 8];
            own_q.push_back(exp_sel);
            rd_q.push_back(w_re);
            exp_q.push_back(model[w_addr[9:2]]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        idle_all();
        // A request held during reset must not reach the memory.
        drive_a(1'b1, 4'h0, 32'h10, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_re", 32'(m_bus.re), 32'h0);
        chk("rst_mem_we", 32'(m_bus.we), 32'h0);
        chk("rst_a_ready", 32'(a_bus.ready), 32'h0);
        chk("rst_b_ready", 32'(b_bus.ready), 32'h0);
        chk("rst_gnt", 32'(dbg_gnt), 32'(SEL_NONE));
        chk("rst_rsp", 32'(dbg_rsp), 32'(SEL_NONE));
        chk("rst_starve", 32'(dbg_starve), 32'h0);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;

        // Single master write then read back.
        drive_a(1'b0, 4'hF, 32'h10, 32'hDEADBEEF); step(SEL_A);
        drive_a(1'b1, 4'h0, 32'h10, 32'h0);        step(SEL_A);
        idle_all();                                step(SEL_NONE);

        // Byte-lane write merged into an existing word.
        drive_a(1'b0, 4'hF,    32'h30, 32'h11223344); step(SEL_A);
        drive_a(1'b0, 4'b0010, 32'h30, 32'h0000AB00); step(SEL_A);
        drive_a(1'b1, 4'h0,    32'h30, 32'h0);        step(SEL_A);
        idle_all();                                   step(SEL_NONE);

        // Back-to-back accepts alternating between masters.
        for (int i = 0; i < 4; i++) begin
            idle_all();
            if (i % 2 == 0) begin
                drive_a(1'b1, 4'h0, 32'h10, 32'h0); step(SEL_A);
            end else begin
                drive_b(1'b1, 4'h0, 32'h30, 32'h0); step(SEL_B);
            end
        end
        idle_all(); step(SEL_NONE);

        // Continuous tie from reset.
        do_reset();
        drive_a(1'b1, 4'h0, 32'h10, 32'h0);
        drive_b(1'b1, 4'h0, 32'h00, 32'h0);
`ifdef BOA_MEM_ARBITER_RR_EN
        for (int i = 0; i < 6; i++) begin
            chk("rr_starve", 32'(dbg_starve), 32'h0);
            step(rr_seq[i]);
        end
`else
        for (int i = 0; i < 8; i++) begin
            chk("fix_starve", 32'(dbg_starve), 32'(fix_stv[i]));
            step(fix_seq[i]);
        end
`endif
        idle_all(); step(SEL_NONE);

        // A write stalled for three cycles while B waits, then B follows.
        mem_ready = 1'b0;
        drive_a(1'b0, 4'hF, 32'h20, 32'hCAFEF00D);
        drive_b(1'b1, 4'h0, 32'h10, 32'h0);
        step(SEL_A);
        chk("lock_gnt", 32'(dbg_gnt), 32'(SEL_A));
        step(SEL_A);
        step(SEL_A);
        mem_ready = 1'b1;
        step(SEL_A);
        drive_a(1'b0, 4'h0, 32'h0, 32'h0);
        step(SEL_B);
        idle_all(); step(SEL_NONE);
        drive_a(1'b1, 4'h0, 32'h20, 32'h0); step(SEL_A);
        idle_all(); step(SEL_NONE);

        // Reset during a stalled B read aborts it with no response.
        mem_ready = 1'b0;
        drive_b(1'b1, 4'h0, 32'h10, 32'h0);
        step(SEL_B);
        chk("abort_lock", 32'(dbg_gnt), 32'(SEL_B));
        rst_n = 1'b0;
        #1;
        chk("abort_mem_re", 32'(m_bus.re), 32'h0);
        chk("abort_b_ready", 32'(b_bus.ready), 32'h0);
        chk("abort_gnt", 32'(dbg_gnt), 32'(SEL_NONE));
        @(negedge clk);
        #1;
        chk("abort_mem_re2", 32'(m_bus.re), 32'h0);
        chk("abort_rsp", 32'(dbg_rsp), 32'(SEL_NONE));
        chk("abort_a_rdata", a_bus.rdata, 32'h0);
        chk("abort_b_rdata", b_bus.rdata, 32'h0);
        idle_all();
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(SEL_NONE);
        step(SEL_NONE);
        chk("queue_empty", 32'(own_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
